// File: rtl/param_alu_pkg.sv
// Shared types and defaults for the parametrised ALU pipeline.
package param_alu_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_ADDS = 2'd1,
        MODE_SUB  = 2'd2,
        MODE_ACC  = 2'd3
    } alu_mode_e;

    localparam int unsigned DEFAULT_W = 4;

endpackage

// File: rtl/param_alu_core.sv
// Combinational datapath: add, saturating add, subtract, accumulate.
module param_alu_core
    import param_alu_pkg::*;
#(
    parameter int unsigned W     = DEFAULT_W,
    parameter int unsigned ACC_W = W
) (
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  alu_mode_e        mode,
    input  logic [ACC_W-1:0] acc_eff,
    output logic [W-1:0]     sum,
    output logic             carry,
    output logic             ovf,
    output logic [ACC_W-1:0] acc_next
);

    logic [W:0]       add_raw;
    logic [W:0]       sub_raw;
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W:0]   acc_raw;

    assign add_raw  = {1'b0, a} + {1'b0, b};
    // Bit W of the extended difference is the unsigned borrow.
    assign sub_raw  = {1'b0, a} - {1'b0, b};
    assign a_ext    = ACC_W'(a);
    assign acc_raw  = {1'b0, acc_eff} + {1'b0, a_ext};
    assign acc_next = acc_raw[ACC_W-1:0];

    always_comb begin
        sum   = add_raw[W-1:0];
        carry = add_raw[W];
        ovf   = (a[W-1] == b[W-1]) && (add_raw[W-1] != a[W-1]);
        unique case (mode)
            MODE_ADD: begin
                sum   = add_raw[W-1:0];
                carry = add_raw[W];
                ovf   = (a[W-1] == b[W-1]) && (add_raw[W-1] != a[W-1]);
            end
            MODE_ADDS: begin
                carry = add_raw[W];
                sum   = add_raw[W] ? '1 : add_raw[W-1:0];
                ovf   = add_raw[W];
            end
            MODE_SUB: begin
                sum   = sub_raw[W-1:0];
                carry = sub_raw[W];
                ovf   = (a[W-1] != b[W-1]) && (sub_raw[W-1] != a[W-1]);
            end
            MODE_ACC: begin
                sum   = acc_next[W-1:0];
                carry = acc_raw[ACC_W];
                ovf   = (acc_eff[ACC_W-1] == a_ext[ACC_W-1]) &&
                        (acc_next[ACC_W-1] != acc_eff[ACC_W-1]);
            end
            default: begin
                sum   = add_raw[W-1:0];
                carry = add_raw[W];
                ovf   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/param_alu_pipe.sv
// Two-stage valid/ready ALU pipeline: operand register (S1) then result register.
module param_alu_pipe
    import param_alu_pkg::*;
#(
    parameter int unsigned W     = DEFAULT_W,
    parameter int unsigned ACC_W = W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [1:0]   in_mode,
    input  logic         acc_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_carry,
    output logic         out_ovf
);

    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_a_q, s1_a_d;
    logic [W-1:0]     s1_b_q, s1_b_d;
    alu_mode_e        s1_mode_q, s1_mode_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_sum_q, out_sum_d;
    logic             out_carry_q, out_carry_d;
    logic             out_ovf_q, out_ovf_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    logic             adv;
    logic             accept;
    logic             move;
    logic [ACC_W-1:0] acc_eff;
    logic [W-1:0]     core_sum;
    logic             core_carry;
    logic             core_ovf;
    logic [ACC_W-1:0] core_acc_next;

    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | adv;
    assign accept   = in_valid & in_ready;
    assign move     = s1_valid_q & adv;
    // Clear takes effect before any accumulate in the same cycle.
    assign acc_eff  = acc_clr ? '0 : acc_q;

    param_alu_core #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_core (
        .a        (s1_a_q),
        .b        (s1_b_q),
        .mode     (s1_mode_q),
        .acc_eff  (acc_eff),
        .sum      (core_sum),
        .carry    (core_carry),
        .ovf      (core_ovf),
        .acc_next (core_acc_next)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_mode_d   = s1_mode_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;
        out_ovf_d   = out_ovf_q;
        acc_d       = acc_eff;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_mode_d  = alu_mode_e'(in_mode);
        end else if (move) begin
            s1_valid_d = 1'b0;
        end

        if (move) begin
            out_valid_d = 1'b1;
            out_sum_d   = core_sum;
            out_carry_d = core_carry;
            out_ovf_d   = core_ovf;
            if (s1_mode_q == MODE_ACC) begin
                acc_d = core_acc_next;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_mode_q   <= MODE_ADD;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            acc_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
            out_ovf_q   <= out_ovf_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_carry = out_carry_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_param_alu_pipe.sv
// Directed self-checking bench for param_alu_pipe at W=4, ACC_W=4.
module tb_param_alu_pipe;

    localparam logic [1:0] M_ADD  = 2'd0;
    localparam logic [1:0] M_ADDS = 2'd1;
    localparam logic [1:0] M_SUB  = 2'd2;
    localparam logic [1:0] M_ACC  = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_mode;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       out_carry;
    logic       out_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    param_alu_pipe #(
        .W     (4),
        .ACC_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One isolated beat with out_ready high: accept, one cycle in S1, then result.
    task automatic op(input string tag, input logic [1:0] mode, input logic [3:0] a,
                      input logic [3:0] b, input logic clr, input logic [3:0] es,
                      input logic ec, input logic eo);
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = mode;
        in_a     = a;
        in_b     = b;
        acc_clr  = clr;
        #1;
        check({tag, "/in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "/lat1"}, out_valid, 0);
        @(negedge clk);
        acc_clr = 1'b0;
        check({tag, "/valid"}, out_valid, 1);
        check({tag, "/sum"}, out_sum, es);
        check({tag, "/carry"}, out_carry, ec);
        check({tag, "/ovf"}, out_ovf, eo);
    endtask

    initial begin
        int sent;
        int rcv;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mode   = M_ADD;
        acc_clr   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst/out_valid", out_valid, 0);
        check("rst/out_sum", out_sum, 0);
        check("rst/flags", {out_carry, out_ovf}, 0);
        reset = 1'b0;
        #1;
        check("rst/in_ready", in_ready, 1);

        op("add_7_9",   M_ADD,  4'd7,  4'd9, 1'b0, 4'd0,  1'b1, 1'b0);
        op("add_7_1",   M_ADD,  4'd7,  4'd1, 1'b0, 4'd8,  1'b0, 1'b1);
        op("adds_12_5", M_ADDS, 4'd12, 4'd5, 1'b0, 4'd15, 1'b1, 1'b1);
        op("adds_3_4",  M_ADDS, 4'd3,  4'd4, 1'b0, 4'd7,  1'b0, 1'b0);
        op("sub_3_5",   M_SUB,  4'd3,  4'd5, 1'b0, 4'd14, 1'b1, 1'b0);
        op("sub_8_1",   M_SUB,  4'd8,  4'd1, 1'b0, 4'd7,  1'b0, 1'b1);

        // Back-to-back accumulate: 3, 7, 3 (wrap with carry)
        @(negedge clk);
        in_valid = 1'b1; in_mode = M_ACC; in_a = 4'd3; in_b = 4'd9;
        @(negedge clk);
        in_a = 4'd4;
        @(negedge clk);
        check("acc1/valid", out_valid, 1);
        check("acc1/sum", out_sum, 3);
        in_a = 4'd12;
        @(negedge clk);
        in_valid = 1'b0;
        check("acc2/sum", out_sum, 7);
        check("acc2/carry", out_carry, 0);
        @(negedge clk);
        check("acc3/valid", out_valid, 1);
        check("acc3/sum", out_sum, 3);
        check("acc3/carry", out_carry, 1);
        check("acc3/ovf", out_ovf, 0);
        @(negedge clk);
        check("acc3/drained", out_valid, 0);

        op("acc_clr_5", M_ACC, 4'd5, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
        op("acc_plus1", M_ACC, 4'd1, 4'd0, 1'b0, 4'd6, 1'b0, 1'b0);
        op("add_keeps_acc", M_ADD, 4'd2, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0);
        op("acc_plus2", M_ACC, 4'd2, 4'd0, 1'b0, 4'd8, 1'b0, 1'b1);

        // Stall: six ADD beats with out_ready low for the first five cycles
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            @(negedge clk);
            if (cyc == 4) check("stall/accepted", sent, 2);
            out_ready = (cyc >= 5);
            in_valid  = (sent < 6);
            in_mode   = M_ADD;
            in_a      = 4'(sent + 1);
            in_b      = 4'd1;
            #1;
            if (cyc == 4) check("stall/in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                check($sformatf("stall/beat%0d", rcv), out_sum, rcv + 2);
                rcv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        check("stall/received", rcv, 6);
        @(negedge clk);
        check("stall/no_dup", out_valid, 0);

        // Reset with two beats in flight
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_mode = M_ADD; in_a = 4'd1; in_b = 4'd1;
        @(negedge clk);
        in_a = 4'd2; in_b = 4'd2;
        @(negedge clk);
        in_valid = 1'b0;
        check("flight/valid", out_valid, 1);
        check("flight/sum", out_sum, 2);
        #1;
        reset = 1'b1;
        #1;
        check("arst/out_valid", out_valid, 0);
        check("arst/out_sum", out_sum, 0);
        check("arst/flags", {out_carry, out_ovf}, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("arst/no_stale%0d", i), out_valid, 0);
        end
        op("arst/acc_zero", M_ACC, 4'd6, 4'd0, 1'b0, 4'd6, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/param_alu_pipe.md
Name: param_alu_pipe

Overview:
Parametrised successor to the nibble adder on the user-project wrapper. Takes two W-bit operands and a 2-bit mode, and computes one of: wrapping add, saturating add, subtract, or accumulate. Operands are accepted through a valid/ready input handshake; results leave through a valid/ready output handshake after a 2-stage pipeline. Sits between the ui_in/uio_in pin decode and the uo_out driver in the top-level wrapper.

Parameters:
W, 4, operand/result width in bits (W >= 2)
ACC_W, W, accumulator width; result returned is low W bits, ACC_W >= W

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept an operand beat this cycle
in_a  input  W  operand A (unsigned; signed view used for ovf)
in_b  input  W  operand B (ignored in ACC mode)
in_mode  input  2  0=ADD, 1=ADDS, 2=SUB, 3=ACC
acc_clr  input  1  synchronous accumulator clear
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
out_sum  output  W  result
out_carry  output  1  carry-out (ADD/ADDS/ACC) or borrow (SUB)
out_ovf  output  1  signed overflow (ADD/SUB/ACC) or saturation occurred (ADDS)

Behaviour:
- Reset (async, active-high): s1_valid=0, out_valid=0, out_sum=0, out_carry=0, out_ovf=0, acc=0. in_ready=1 immediately after reset deasserts.
- Transfer rules: input beat accepted when in_valid & in_ready. Output beat consumed when out_valid & out_ready.
- Stage 1 (S1): registers a, b, mode on accept.
- Stage 2 (output regs): computes from S1 and registers the result.
- Advance condition: adv = ~out_valid | out_ready. S1 moves into stage 2 when s1_valid & adv. in_ready = ~s1_valid | adv (combinational, no dependence on in_valid).
- Latency: accept in cycle N -> out_valid in cycle N+2 when not stalled. Throughput is 1 beat/cycle with out_ready held high.
- Stall: while out_valid & ~out_ready, all output regs hold. S1 holds its beat. in_ready=0 once S1 is full. No beat is lost, duplicated, or reordered.
- Output register update on a consumed beat with no new data: out_valid drops to 0; sum and flags hold their last values.
- ADD: out_sum = (a+b) mod 2^W. out_carry = bit W of the sum. out_ovf = signed overflow (sign(a)==sign(b) and sign(sum)!=sign(a)).
- ADDS: if a+b >= 2^W, out_sum = all ones and out_ovf=1; otherwise out_sum = a+b and out_ovf=0. out_carry = raw bit W.
- SUB: out_sum = (a-b) mod 2^W. out_carry = 1 iff a<b (unsigned borrow). out_ovf = signed overflow (sign(a)!=sign(b) and sign(result)!=sign(a)).
- ACC: acc_next = (acc_eff + zero-extended a) mod 2^ACC_W. out_sum = acc_next[W-1:0]. out_carry = carry out of bit ACC_W-1. out_ovf = signed overflow at ACC_W. acc <= acc_next.
- Accumulator update timing: acc is updated only in the cycle the ACC beat advances from S1 to stage 2. A stalled ACC beat does not update acc.
- acc_clr: acc_eff = acc_clr ? 0 : acc.
  - acc_clr with no ACC beat advancing: acc <= 0.
  - acc_clr in the same cycle an ACC beat advances: clear applies first, so the result equals a.
  - Non-ACC modes never modify acc.
- Reset mid-operation: any in-flight beats are discarded and no out_valid follows. acc=0.
- Operand, mode, and acc_clr values are don't-care when in_valid=0, except acc_clr, which is always honoured.

Decomposition:
- Package param_alu_pkg: typedef enum logic [1:0] alu_mode_e {MODE_ADD, MODE_ADDS, MODE_SUB, MODE_ACC}; localparam DEFAULT_W = 4.
- Sub-module param_alu_core: purely combinational, parametrised by W and ACC_W. Inputs: a, b, mode, acc_eff. Outputs: sum, carry, ovf, acc_next.
- param_alu_pipe owns S1, the output registers, the acc register, and the handshake.

Test Plan (W=4, ACC_W=4):
- ADD a=7, b=9, out_ready=1 -> 2 cycles later out_valid=1, out_sum=0, carry=1, ovf=0. ADD a=7, b=1 -> sum=8, carry=0, ovf=1.
- ADDS a=12, b=5 -> sum=15, ovf=1, carry=1. ADDS a=3, b=4 -> sum=7, ovf=0.
- SUB a=3, b=5 -> sum=14, carry=1, ovf=0. SUB a=8, b=1 -> sum=7, carry=0, ovf=1.
- ACC a=3,4,12 back-to-back -> sums 3,7,3. Third beat has carry=1. Then ACC a=5 with acc_clr=1 -> sum=5.
- Stream 6 ADD beats with out_ready=0 for 5 cycles -> in_ready=0 after 2 beats accepted. After release, all 6 results appear in order, none missing or duplicated.
- Assert reset while 2 beats are in flight -> out_valid=0, out_sum=0, acc=0 immediately. No stale result appears after reset deasserts.
